bist_signature_checker: RTL and testbench

Run controller and response checker for the 16-bit adder BIST core. It drives the core's active-high `rst` and waits for `finish`. It then captures the 17-bit `signature`, compares it against a golden value, and reports pass, fail or timeout. It is the consuming end of the core's `rst`/`finish`/`signature` interface and replaces the bench-level `wait(finish)` with synthesizable on-chip checking.

---
 rtl/bist_chk_pkg.sv | 16 +
 rtl/bist_chk_timer.sv | 39 +++
 rtl/bist_signature_checker.sv | 139 +++++++++++++
 tb/tb_bist_signature_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_chk_pkg.sv
// Shared types and defaults for the BIST signature checker.
// BIST_CHK_RETRY_EN (optional) enables the RETRY state in the top.
package bist_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RETRY = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  localparam int          SIG_W_DEF   = 17;
  localparam int          TIMEOUT_DEF = 200;
  localparam logic [16:0] GOLDEN_DEF  = 17'h0;

endpackage

// File: rtl/bist_chk_timer.sv
// Saturating RUN-cycle counter. count_o is the value as of the current cycle
// (first enabled cycle after a clear reads 1).
module bist_chk_timer
  import bist_chk_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_d;
  assign expired_o = en_i && (count_d == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bist_signature_checker.sv
// Run controller and golden-signature checker for the adder BIST core.
// Optional retry on failure is compiled in with BIST_CHK_RETRY_EN.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// RUN   | core released, counting cycles until finish or timeout
// RETRY | one-cycle core reset between a failed run and its re-run
// DONE  | result valid and held, core held in reset
module bist_signature_checker
  import bist_chk_pkg::*;
#(
  parameter int               SIG_W     = SIG_W_DEF,
  parameter logic [SIG_W-1:0] GOLDEN    = SIG_W'(GOLDEN_DEF),
  parameter int               TIMEOUT   = TIMEOUT_DEF,
  parameter int               CNT_W     = 8,
  parameter int               MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             bist_rst,
  input  logic             bist_finish,
  input  logic [SIG_W-1:0] bist_signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [SIG_W-1:0] sig_out,
  output logic [CNT_W-1:0] run_cycles,
  output logic [1:0]       retry_cnt
);

  if ((2 ** CNT_W) <= TIMEOUT || MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_param_err
    $error("bist_signature_checker: CNT_W too small for TIMEOUT or MAX_RETRY out of range");
  end

  chk_state_e       state_q;
  logic             bist_rst_q, busy_q, done_q, pass_q, timeout_q;
  logic [SIG_W-1:0] sig_q;
  logic [CNT_W-1:0] run_cycles_q;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expired;
  logic             launch, run_end, run_ok, retry_ok;

  assign launch  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign run_end = bist_finish || tmr_expired;
  // Finish on the timeout cycle counts as a normal completion.
  assign run_ok  = bist_finish && (bist_signature == GOLDEN);

`ifdef BIST_CHK_RETRY_EN
  logic [1:0] retry_cnt_q;
  assign retry_ok  = !run_ok && (retry_cnt_q < 2'(MAX_RETRY));
  assign retry_cnt = retry_cnt_q;
`else
  assign retry_ok  = 1'b0;
  assign retry_cnt = 2'b00;
`endif

  bist_chk_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (launch || (state_q == ST_RETRY)),
    .en_i      (state_q == ST_RUN),
    .count_o   (tmr_count),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bist_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      sig_q        <= '0;
      run_cycles_q <= '0;
`ifdef BIST_CHK_RETRY_EN
      retry_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state_q    <= ST_RUN;
            bist_rst_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef BIST_CHK_RETRY_EN
            retry_cnt_q <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (run_end) begin
            sig_q        <= bist_signature;
            run_cycles_q <= tmr_count;
            pass_q       <= run_ok;
            timeout_q    <= !bist_finish;
            bist_rst_q   <= 1'b1;
            if (retry_ok) begin
              state_q <= ST_RETRY;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
`ifdef BIST_CHK_RETRY_EN
        ST_RETRY: begin
          state_q     <= ST_RUN;
          bist_rst_q  <= 1'b0;
          retry_cnt_q <= retry_cnt_q + 1'b1;
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          bist_rst_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bist_rst   = bist_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign sig_out    = sig_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Scoreboard bench for bist_signature_checker; the core is modelled inline.
// Expectations follow BIST_CHK_RETRY_EN when the bench is built with it.
module tb_bist_signature_checker;

  localparam int          SIG_W = 17;
  localparam logic [16:0] GOLD  = 17'h0ABCD;
  localparam int          TMO   = 200;
  localparam int          CW    = 8;
  localparam int          MAXR  = 2;
`ifdef BIST_CHK_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              bist_finish = 1'b0;
  logic [SIG_W-1:0]  bist_signature = '0;
  logic              bist_rst, busy, done, pass, timeout;
  logic [SIG_W-1:0]  sig_out;
  logic [CW-1:0]     run_cycles;
  logic [1:0]        retry_cnt;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [16:0] sig;
    logic [7:0]  cycles;
    logic [1:0]  retries;
  } res_t;

  res_t        exp_q[$];
  logic [16:0] sig_tab[3];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  bist_signature_checker #(
    .SIG_W     (SIG_W),
    .GOLDEN    (GOLD),
    .TIMEOUT   (TMO),
    .CNT_W     (CW),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bist_rst       (bist_rst),
    .bist_finish    (bist_finish),
    .bist_signature (bist_signature),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .sig_out        (sig_out),
    .run_cycles     (run_cycles),
    .retry_cnt      (retry_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected final result: each run uses sig_tab[run], same finish cycle.
  function automatic res_t model(int fin_at);
    res_t r;
    r = '0;
    for (int i = 0; i <= MAXR; i++) begin
      if (fin_at >= 1 && fin_at <= TMO) begin
        r.pass    = (sig_tab[i] == GOLD);
        r.timeout = 1'b0;
        r.cycles  = 8'(fin_at);
      end else begin
        r.pass    = 1'b0;
        r.timeout = 1'b1;
        r.cycles  = 8'(TMO);
      end
      r.sig     = sig_tab[i];
      r.retries = 2'(i);
      if (r.pass || !RETRY_ON) break;
    end
    return r;
  endfunction

  task automatic launch(string name, int fin_at);
    exp_q.push_back(model(fin_at));
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (bist_rst !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL %s launch: bist_rst=%b busy=%b done=%b pass=%b, required 0 1 0 0",
               name, bist_rst, busy, done, pass);
    end
  endtask

  // Drives the core model cycle by cycle until done rises or the budget ends.
  task automatic run_wait(int fin_at, int start_at, output int last_cnt,
                          output int retries, output bit got);
    int cnt = 0;
    int idx = 0;
    got = 1'b0;
    retries = 0;
    last_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      if (bist_rst === 1'b0) begin
        cnt++;
        bist_finish    = (cnt == fin_at);
        bist_signature = sig_tab[idx];
        start          = (start_at != 0 && cnt == start_at);
      end else begin
        bist_finish = 1'b0;
        start       = 1'b0;
        if (busy === 1'b1) begin
          retries++;
          if (idx < 2) idx++;
          cnt = 0;
        end
      end
      step();
      if (done === 1'b1) begin
        got = 1'b1;
        last_cnt = cnt;
        break;
      end
    end
    bist_finish = 1'b0;
    start = 1'b0;
  endtask

  task automatic sb_compare(string name, int last_cnt, int retries, bit got);
    res_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: queue empty, required one entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_fail++;
      $display("FAIL %s done: not seen within budget, required done=1", name);
      return;
    end
    n_checks++;
    if (pass !== e.pass) begin
      n_fail++; $display("FAIL %s pass: got %b required %b", name, pass, e.pass);
    end
    n_checks++;
    if (timeout !== e.timeout) begin
      n_fail++; $display("FAIL %s timeout: got %b required %b", name, timeout, e.timeout);
    end
    n_checks++;
    if (sig_out !== e.sig) begin
      n_fail++; $display("FAIL %s sig_out: got %h required %h", name, sig_out, e.sig);
    end
    n_checks++;
    if (run_cycles !== e.cycles) begin
      n_fail++; $display("FAIL %s run_cycles: got %0d required %0d", name, run_cycles, e.cycles);
    end
    n_checks++;
    if (retry_cnt !== e.retries || retries != int'(e.retries)) begin
      n_fail++;
      $display("FAIL %s retry_cnt: got %0d (observed %0d retry cycles) required %0d",
               name, retry_cnt, retries, e.retries);
    end
    n_checks++;
    if (last_cnt != int'(e.cycles)) begin
      n_fail++; $display("FAIL %s done latency: done after run cycle %0d required %0d",
                         name, last_cnt, e.cycles);
    end
    n_checks++;
    if (bist_rst !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s idle outputs: bist_rst=%b busy=%b required 1 0",
                         name, bist_rst, busy);
    end
  endtask

  task automatic scenario(string name, int fin_at, int start_at);
    int  lc, rt;
    bit  got;
    launch(name, fin_at);
    run_wait(fin_at, start_at, lc, rt, got);
    sb_compare(name, lc, rt, got);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    step();
    step();
    n_checks++;
    if (bist_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        timeout !== 1'b0 || sig_out !== '0 || run_cycles !== '0 || retry_cnt !== 2'b0) begin
      n_fail++;
      $display("FAIL reset: bist_rst=%b busy=%b done=%b pass=%b timeout=%b sig=%h cyc=%0d rc=%0d, required 1 0 0 0 0 0 0 0",
               bist_rst, busy, done, pass, timeout, sig_out, run_cycles, retry_cnt);
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || bist_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b bist_rst=%b required 0 1", busy, bist_rst);
    end
  endtask

  task automatic test_normal_pass();
    for (int i = 0; i < 3; i++) sig_tab[i] = GOLD;
    scenario("normal_pass", 50, 0);
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < 3; i++) sig_tab[i] = 17'h12345;
    scenario("mismatch", 60, 0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) sig_tab[i] = 17'h1F00F;
    scenario("no_finish", 0, 0);
  endtask

  task automatic test_finish_at_timeout();
    for (int i = 0; i < 3; i++) sig_tab[i] = GOLD;
    scenario("finish_at_timeout", TMO, 0);
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 20; k++) step();
    rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bist_rst !== 1'b1 || pass !== 1'b0 ||
        timeout !== 1'b0 || run_cycles !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b bist_rst=%b pass=%b timeout=%b cyc=%0d, required 0 0 1 0 0 0",
               busy, done, bist_rst, pass, timeout, run_cycles);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < 3; i++) sig_tab[i] = GOLD;
    scenario("busy_start", 40, 15);
  endtask

  task automatic test_retry();
    sig_tab[0] = 17'h12345;
    sig_tab[1] = GOLD;
    sig_tab[2] = GOLD;
    scenario("retry", 30, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) sig_tab[i] = GOLD;
    scenario("b2b_first_cycle", 1, 0);
    sig_tab[0] = 17'h00001;
    sig_tab[1] = 17'h00002;
    sig_tab[2] = 17'h00003;
    scenario("b2b_fail", 7, 0);
  endtask

  initial begin
    test_reset();
    test_normal_pass();
    test_mismatch();
    test_timeout();
    test_finish_at_timeout();
    test_reset_midrun();
    test_busy_start();
    test_retry();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
